// File: rtl/inst_stream_mem_if.sv
// inst_stream_mem_if: loader handshake and instruction fetch bus of inst_stream_mem
//   ld_valid/ld_data/ld_last : loader word offer (master -> slave)
//   ld_ready                 : slave accepts loader word this cycle
//   pcf                      : processor byte fetch address (master -> slave)
//   inst                     : instruction returned to processor (slave -> master)
interface inst_stream_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] pcf;
    logic [DATA_W-1:0] inst;
    modport master (output ld_valid, ld_data, ld_last, pcf, input ld_ready, inst);
    modport slave  (input ld_valid, ld_data, ld_last, pcf, output ld_ready, inst);
endinterface

// File: rtl/inst_stream_mem.sv
// inst_stream_mem: instruction store with streaming loader, processor reset control and end detection
//   clk, rst      : clock, synchronous active-high reset
//   load_start_i  : pulse, (re)start loading at word 0
//   bus           : loader handshake and fetch port (slave side)
//   cpu_rst_o     : processor reset, high except while running
//   prog_len_o    : words loaded
//   running_o     : processor released
//   done_o        : program end detected
//   trunc_o       : memory filled without ld_last
module inst_stream_mem #(
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 64,
    parameter int              ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'hE1A00000,
    parameter int              HALT_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start_i,
    inst_stream_mem_if.slave           bus,
    output logic                       cpu_rst_o,
    output logic [$clog2(DEPTH+1)-1:0] prog_len_o,
    output logic                       running_o,
    output logic                       done_o,
    output logic                       trunc_o
);
    localparam int PL_W   = $clog2(DEPTH+1);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int HW     = $clog2(HALT_CYC+1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state_q;
    logic [PL_W-1:0]   prog_len_q;
    logic [HW-1:0]     halt_q, halt_d;
    logic              ld_ready_q, cpu_rst_q, running_q, done_q, trunc_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range, xfer, unused_lsb;

    assign xfer       = bus.ld_valid & ld_ready_q;
    assign unused_lsb = ^bus.pcf[1:0];

    always_comb begin
        idx      = bus.pcf[ADDR_W-1:2];
        in_range = idx < IDX_W'(prog_len_q);
        bus.inst = in_range ? mem[idx[MEM_AW-1:0]] : NOP_WORD;
        halt_d   = in_range ? '0 : (halt_q == HW'(HALT_CYC) ? halt_q : halt_q + 1'b1);
    end

    // prog_len_q doubles as the write pointer: both advance together on every accepted word
    always_ff @(posedge clk) begin
        if (!rst && !load_start_i && xfer)
            mem[prog_len_q[MEM_AW-1:0]] <= bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prog_len_q <= '0;
            halt_q     <= '0;
            ld_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else if (load_start_i) begin
            state_q    <= LOAD;
            prog_len_q <= '0;
            halt_q     <= '0;
            ld_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (xfer) begin
                    prog_len_q <= prog_len_q + 1'b1;
                    if (bus.ld_last || prog_len_q == PL_W'(DEPTH-1)) begin
                        state_q    <= RUN;
                        ld_ready_q <= 1'b0;
                        cpu_rst_q  <= 1'b0;
                        running_q  <= 1'b1;
                        trunc_q    <= !bus.ld_last;
                    end
                end
                RUN: begin
                    halt_q <= halt_d;
                    if (halt_d == HW'(HALT_CYC)) begin
                        state_q   <= DONE;
                        cpu_rst_q <= 1'b1;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign prog_len_o   = prog_len_q;
    assign running_o    = running_q;
    assign done_o       = done_q;
    assign trunc_o      = trunc_q;
endmodule

// File: tb/tb_inst_stream_mem.sv
// tb_inst_stream_mem: directed bench for inst_stream_mem (DEPTH=64 instance a, DEPTH=4 instance b)
module tb_inst_stream_mem;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk = 1'b0;
    logic rst, ls_a, ls_b;
    logic       cpu_rst_a, running_a, done_a, trunc_a;
    logic       cpu_rst_b, running_b, done_b, trunc_b;
    logic [6:0] len_a;
    logic [2:0] len_b;
    int vectors = 0;
    int fails   = 0;
    logic [31:0] prog [4] = '{32'hE04F000F, 32'hE2802005, 32'hE0812003, 32'hE2437009};

    always #5 clk = ~clk;

    inst_stream_mem_if #(.DATA_W(32), .ADDR_W(32)) ia ();
    inst_stream_mem_if #(.DATA_W(32), .ADDR_W(32)) ib ();

    inst_stream_mem #(.DEPTH(64)) dut_a (
        .clk(clk), .rst(rst), .load_start_i(ls_a), .bus(ia),
        .cpu_rst_o(cpu_rst_a), .prog_len_o(len_a), .running_o(running_a),
        .done_o(done_a), .trunc_o(trunc_a)
    );

    inst_stream_mem #(.DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .load_start_i(ls_b), .bus(ib),
        .cpu_rst_o(cpu_rst_b), .prog_len_o(len_b), .running_o(running_b),
        .done_o(done_b), .trunc_o(trunc_b)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch_a(input logic [31:0] a, input logic [31:0] exp, input string tag);
        ia.pcf = a;
        #1;
        chk(tag, ia.inst, exp);
    endtask

    task automatic reset_vals_a(input string tag);
        chk({tag, " ld_ready"}, 32'(ia.ld_ready), 0);
        chk({tag, " cpu_rst"}, 32'(cpu_rst_a), 1);
        chk({tag, " running"}, 32'(running_a), 0);
        chk({tag, " done"}, 32'(done_a), 0);
        chk({tag, " trunc"}, 32'(trunc_a), 0);
        chk({tag, " prog_len"}, 32'(len_a), 0);
        fetch_a(0, NOP, {tag, " inst"});
    endtask

    initial begin
        rst = 1; ls_a = 0; ls_b = 0;
        ia.ld_valid = 0; ia.ld_data = 0; ia.ld_last = 0; ia.pcf = 0;
        ib.ld_valid = 0; ib.ld_data = 0; ib.ld_last = 0; ib.pcf = 0;
        tick(2);
        reset_vals_a("rst");
        chk("rst b cpu_rst", 32'(cpu_rst_b), 1);
        rst = 0;
        // word offered in IDLE is ignored
        ia.ld_valid = 1; ia.ld_data = 32'h12345678;
        tick();
        chk("idle ld_ready", 32'(ia.ld_ready), 0);
        chk("idle prog_len", 32'(len_a), 0);
        ia.ld_valid = 0;
        ls_a = 1;
        tick();
        ls_a = 0;
        chk("load ld_ready", 32'(ia.ld_ready), 1);
        chk("load cpu_rst", 32'(cpu_rst_a), 1);
        // backpressure: valid toggles 1,0,1,0...
        for (int k = 0; k < 4; k++) begin
            ia.ld_valid = 1; ia.ld_data = prog[k]; ia.ld_last = (k == 3);
            if (k == 3) chk("accept cyc cpu_rst", 32'(cpu_rst_a), 1);
            tick();
            chk($sformatf("bp len%0d", k), 32'(len_a), k + 1);
            ia.ld_valid = 0; ia.ld_last = 0;
            if (k < 3) begin
                ia.ld_data = 32'hBAD0BAD0;
                tick();
                chk($sformatf("bp hold%0d", k), 32'(len_a), k + 1);
            end
        end
        chk("run cpu_rst", 32'(cpu_rst_a), 0);
        chk("run running", 32'(running_a), 1);
        chk("run ld_ready", 32'(ia.ld_ready), 0);
        chk("run trunc", 32'(trunc_a), 0);
        // word offered in RUN is ignored
        ia.ld_valid = 1; ia.ld_data = 32'hDEADBEEF;
        tick();
        ia.ld_valid = 0;
        chk("run ignore len", 32'(len_a), 4);
        fetch_a(0, prog[0], "pcf0");
        fetch_a(4, prog[1], "pcf4");
        fetch_a(8, prog[2], "pcf8");
        fetch_a(12, prog[3], "pcf12");
        fetch_a(13, prog[3], "pcf13 alias");
        fetch_a(16, NOP, "pcf16");
        // 3 out-of-range cycles then in-range clears the counter
        tick(3);
        chk("halt3 done", 32'(done_a), 0);
        ia.pcf = 0;
        tick();
        chk("clear done", 32'(done_a), 0);
        ia.pcf = 16;
        tick(3);
        chk("halt3b done", 32'(done_a), 0);
        chk("halt3b running", 32'(running_a), 1);
        tick();
        chk("halt4 done", 32'(done_a), 1);
        chk("halt4 cpu_rst", 32'(cpu_rst_a), 1);
        chk("halt4 running", 32'(running_a), 0);
        tick(2);
        chk("done held", 32'(done_a), 1);
        // reload from DONE; load_start with an accepted word discards it
        ls_a = 1;
        tick();
        ls_a = 0;
        chk("reload done", 32'(done_a), 0);
        chk("reload len", 32'(len_a), 0);
        ia.ld_valid = 1; ia.ld_data = 32'h11111111;
        tick();
        chk("reload w1 len", 32'(len_a), 1);
        ia.ld_data = 32'h22222222; ls_a = 1;
        tick();
        ls_a = 0;
        chk("restart len", 32'(len_a), 0);
        chk("restart ld_ready", 32'(ia.ld_ready), 1);
        ia.ld_data = 32'h33333333;
        tick();
        ia.ld_data = 32'h44444444; ia.ld_last = 1;
        tick();
        ia.ld_valid = 0; ia.ld_last = 0;
        chk("reload2 len", 32'(len_a), 2);
        chk("reload2 running", 32'(running_a), 1);
        chk("reload2 trunc", 32'(trunc_a), 0);
        chk("reload2 done", 32'(done_a), 0);
        fetch_a(0, 32'h33333333, "new pcf0");
        fetch_a(4, 32'h44444444, "new pcf4");
        fetch_a(8, NOP, "new pcf8");
        // reset in the middle of a load
        ls_a = 1;
        tick();
        ls_a = 0;
        ia.ld_valid = 1; ia.ld_data = 32'h55555555;
        tick(2);
        chk("midload len", 32'(len_a), 2);
        rst = 1;
        tick();
        ia.ld_valid = 0;
        reset_vals_a("midrst");
        rst = 0;
        tick();
        // DEPTH=4 instance: 6 words without ld_last
        ls_b = 1;
        tick();
        ls_b = 0;
        ib.ld_valid = 1;
        for (int k = 0; k < 6; k++) begin
            ib.ld_data = 32'hA0 + 32'(k);
            tick();
            chk($sformatf("trunc len%0d", k), 32'(len_b), (k < 4) ? k + 1 : 4);
        end
        ib.ld_valid = 0;
        chk("trunc flag", 32'(trunc_b), 1);
        chk("trunc running", 32'(running_b), 1);
        chk("trunc ld_ready", 32'(ib.ld_ready), 0);
        ib.pcf = 12;
        #1;
        chk("trunc pcf12", ib.inst, 32'hA3);
        ib.pcf = 16;
        #1;
        chk("trunc pcf16", ib.inst, NOP);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
